// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch and load/store) in front of one single-port memory.
// Round-robin on ties, one outstanding access at a time, with a sticky timeout flag.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   // fetch requester
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   // load/store requester
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   // shared memory
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   // pipeline control and status
   output logic        stall_if,
   output logic        stall_m,
   output logic        err,
   output logic [1:0]  dbgState
);

   // Handshake: a requester raises req with stable fields and keeps it high until it
   // sees its ready pulse (one cycle, rdata valid alongside it). The memory sees mem_en
   // for one cycle and may answer with mem_ack in that cycle or any later one.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } stateE;

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   stateE       state;
   stateE       nextState;
   logic        lastGrant;     // 0 = fetch, 1 = data
   logic        grantD;        // winner of the transaction in flight
   logic [31:0] latAddr;
   logic        latWe;
   logic [31:0] latWdata;
   logic [7:0]  toCnt;
   logic [7:0]  cntNext;
   logic        errQ;
   logic [31:0] ifRdataQ;
   logic [31:0] dRdataQ;

   logic        anyReq;
   logic        pickD;
   logic        busy;
   logic        timeoutHit;

   assign anyReq  = if_req | d_req;
   // On a tie the data side wins unless it was the one granted last.
   assign pickD   = d_req & (~if_req | ~lastGrant);
   assign busy    = (state == ISSUE) || (state == WAIT);
   assign cntNext = toCnt + 8'd1;
   // An ack in the boundary cycle suppresses the timeout.
   assign timeoutHit = busy && !mem_ack && (cntNext == TimeoutCnt);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (anyReq) nextState = ISSUE;
         end
         ISSUE, WAIT: begin
            if (mem_ack || timeoutHit) nextState = DONE;
            else                       nextState = WAIT;
         end
         DONE: begin
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lastGrant <= 1'b0;
         grantD    <= 1'b0;
         latAddr   <= '0;
         latWe     <= 1'b0;
         latWdata  <= '0;
         toCnt     <= '0;
         errQ      <= 1'b0;
         ifRdataQ  <= '0;
         dRdataQ   <= '0;
      end else begin
         if (state == IDLE && anyReq) begin
            grantD    <= pickD;
            lastGrant <= pickD;
            latAddr   <= pickD ? d_addr : if_addr;
            latWe     <= pickD & d_we;
            latWdata  <= pickD ? d_wdata : '0;
            toCnt     <= '0;
         end else if (busy) begin
            if (mem_ack) begin
               if (grantD) dRdataQ  <= mem_rdata;
               else        ifRdataQ <= mem_rdata;
            end else begin
               toCnt <= cntNext;
               if (timeoutHit) begin
                  errQ <= 1'b1;
                  if (grantD) dRdataQ  <= '0;
                  else        ifRdataQ <= '0;
               end
            end
         end
      end
   end

   // Memory fields are only driven while an access is open so idle buses read as zero.
   always_comb begin
      mem_en    = (state == ISSUE);
      mem_we    = busy & latWe;
      mem_addr  = busy ? latAddr : '0;
      mem_wdata = busy ? latWdata : '0;
      if_ready  = (state == DONE) & ~grantD;
      d_ready   = (state == DONE) & grantD;
      if_rdata  = ifRdataQ;
      d_rdata   = dRdataQ;
      err       = errQ;
      stall_if  = if_req & ~if_ready;
      stall_m   = d_req & ~d_ready;
      dbgState  = state;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration order, latency, stalls,
// timeout handling and asynchronous reset, all with hand-computed expectations.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall_if;
   logic        stall_m;
   logic        err;
   logic [1:0]  dbgState;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_if(stall_if), .stall_m(stall_m), .err(err), .dbgState(dbgState)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, 32'(dbgState), 32'd0);
      check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check({tag, "_mem_addr"}, mem_addr, 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_if_ready"}, 32'(if_ready), 32'd0);
      check({tag, "_d_ready"}, 32'(d_ready), 32'd0);
      check({tag, "_if_rdata"}, if_rdata, 32'd0);
      check({tag, "_d_rdata"}, d_rdata, 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check_reset_values("rst");
      tick();
      reset = 1'b1;
   endtask

   initial begin
      int n;
      int enCount;
      int rdyCount;
      bit seenReady;

      reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
      #2;
      check_reset_values("por");
      tick();
      reset = 1'b1;

      // Single fetch, ack in ISSUE
      if_req = 1'b1; if_addr = 32'h100;
      tick();
      check("f_mem_en", 32'(mem_en), 32'd1);
      check("f_mem_addr", mem_addr, 32'h100);
      check("f_mem_we", 32'(mem_we), 32'd0);
      check("f_stall_if", 32'(stall_if), 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h00500093;
      tick();
      check("f_if_ready", 32'(if_ready), 32'd1);
      check("f_if_rdata", if_rdata, 32'h00500093);
      check("f_mem_en_done", 32'(mem_en), 32'd0);
      check("f_stall_if_done", 32'(stall_if), 32'd0);
      mem_ack = 1'b0; if_req = 1'b0;
      tick();
      check("f_if_ready_low", 32'(if_ready), 32'd0);
      check("f_if_rdata_hold", if_rdata, 32'h00500093);

      // Tie from reset: data first, then fetch
      do_reset();
      if_req = 1'b1; if_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
      tick();
      check("t_mem_we", 32'(mem_we), 32'd1);
      check("t_mem_addr", mem_addr, 32'h200);
      check("t_mem_wdata", mem_wdata, 32'hDEADBEEF);
      check("t_stall_if", 32'(stall_if), 32'd1);
      check("t_stall_m", 32'(stall_m), 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h11111111;
      tick();
      check("t_d_ready", 32'(d_ready), 32'd1);
      check("t_if_ready", 32'(if_ready), 32'd0);
      check("t_d_rdata", d_rdata, 32'h11111111);
      mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
      tick();
      tick();
      check("t2_mem_addr", mem_addr, 32'h300);
      check("t2_mem_we", 32'(mem_we), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h22222222;
      tick();
      check("t2_if_ready", 32'(if_ready), 32'd1);
      check("t2_if_rdata", if_rdata, 32'h22222222);
      check("t2_d_rdata_hold", d_rdata, 32'h11111111);
      mem_ack = 1'b0; if_req = 1'b0;
      tick();

      // Six back-to-back ties alternate D,I,D,I,D,I (last grant was fetch)
      if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_addr = 32'h200;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rr_addr", mem_addr, (i % 2 == 0) ? 32'h200 : 32'h300);
         mem_ack = 1'b1; mem_rdata = 32'h1000 + 32'(i);
         tick();
         check("rr_d_ready", 32'(d_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("rr_if_ready", 32'(if_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
         mem_ack = 1'b0;
         tick();
      end
      check("rr_d_rdata", d_rdata, 32'h1004);
      check("rr_if_rdata", if_rdata, 32'h1005);
      if_req = 1'b0; d_req = 1'b0;
      tick();

      // Load with ack three cycles after ISSUE; fields changed mid-flight
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
      enCount = 0; rdyCount = 0; seenReady = 1'b0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         tick();
         enCount += int'(mem_en);
         rdyCount += int'(d_ready);
         if (!seenReady && !d_ready) check("sl_stall_m", 32'(stall_m), 32'd1);
         if (cyc == 3) check("sl_addr_latched", mem_addr, 32'h400);
         if (d_ready) begin
            seenReady = 1'b1;
            check("sl_ready_cycle", 32'(cyc), 32'd5);
            d_req = 1'b0;
         end
         if (cyc == 2) d_addr = 32'hFFF0;
         mem_ack = (cyc == 4);
         mem_rdata = 32'hCAFEF00D;
      end
      mem_ack = 1'b0;
      check("sl_en_count", 32'(enCount), 32'd1);
      check("sl_rdy_count", 32'(rdyCount), 32'd1);
      check("sl_d_rdata", d_rdata, 32'hCAFEF00D);

      // No ack at all: timeout after 15 ISSUE/WAIT cycles
      d_req = 1'b1; d_addr = 32'h500;
      n = 0;
      do begin
         tick();
         n++;
         if (n == 15) begin
            check("to_err_before", 32'(err), 32'd0);
            check("to_state_wait", 32'(dbgState), 32'd2);
         end
      end while (!d_ready && n < 40);
      check("to_cycles", 32'(n), 32'd16);
      check("to_d_ready", 32'(d_ready), 32'd1);
      check("to_err", 32'(err), 32'd1);
      check("to_d_rdata", d_rdata, 32'd0);
      d_req = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("to_err_sticky", 32'(err), 32'd1);

      // Reset asserted in WAIT, request kept pending
      d_req = 1'b1; d_addr = 32'h600;
      tick();
      tick();
      check("ra_state_wait", 32'(dbgState), 32'd2);
      reset = 1'b0;
      #1;
      check_reset_values("ra");
      check("ra_stall_m", 32'(stall_m), 32'd1);
      tick();
      check("ra_no_ready", 32'(d_ready), 32'd0);
      reset = 1'b1;
      tick();
      check("ra_reissue_en", 32'(mem_en), 32'd1);
      check("ra_reissue_addr", mem_addr, 32'h600);
      mem_ack = 1'b1; mem_rdata = 32'h600AAAAA;
      tick();
      check("ra_d_ready", 32'(d_ready), 32'd1);
      check("ra_d_rdata", d_rdata, 32'h600AAAAA);
      mem_ack = 1'b0; d_req = 1'b0;
      tick();

      // Ack in the cycle the count reaches TIMEOUT wins
      d_req = 1'b1; d_addr = 32'h700;
      for (int k = 0; k < 15; k++) tick();
      mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
      tick();
      check("bd_d_ready", 32'(d_ready), 32'd1);
      check("bd_d_rdata", d_rdata, 32'h5A5A5A5A);
      check("bd_err", 32'(err), 32'd0);
      mem_ack = 1'b0; d_req = 1'b0;
      tick();

      // Stray ack in IDLE is ignored
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      tick();
      check("ia_state", 32'(dbgState), 32'd0);
      check("ia_d_rdata", d_rdata, 32'h5A5A5A5A);
      check("ia_if_rdata", if_rdata, 32'd0);
      check("ia_mem_en", 32'(mem_en), 32'd0);
      mem_ack = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max cycles in ISSUE+WAIT without mem_ack before forced completion (legal range 2..255).
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous active-low reset (0 = in reset).
REQ-004 SHALL have ports if_req in 1, if_addr in 32, if_rdata out 32, if_ready out 1: fetch-stage read requester.
REQ-005 SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32, d_rdata out 32, d_ready out 1: memory-stage load/store requester.
REQ-006 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32, mem_ack in 1: shared single-port memory.
REQ-007 SHALL have ports stall_if out 1, stall_m out 1: pipeline hold for fetch/decode and for execute/memory.
REQ-008 SHALL have port err out 1: sticky timeout flag.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-010 IDLE: no request -> stay; any request -> latch winner id, addr, we, wdata -> ISSUE next cycle.
REQ-011 Arbitration: only one requesting wins; both requesting -> grant the one NOT granted last (round-robin via last_grant bit).
REQ-012 last_grant SHALL update on every grant; reset value = IF, so first tie goes to data.
REQ-013 ISSUE: mem_en=1 for exactly one cycle, mem_addr/mem_we/mem_wdata from latched values; mem_we=0 for IF grants.
REQ-014 mem_addr/mem_we/mem_wdata SHALL hold latched values through ISSUE and WAIT; mem_en=0 in all other states.
REQ-015 mem_ack=1 in ISSUE or WAIT -> capture mem_rdata -> DONE; ISSUE without ack -> WAIT; WAIT without ack -> WAIT.
REQ-016 mem_ack in IDLE or DONE SHALL be ignored.
REQ-017 DONE: pulse the winner's ready for exactly one cycle with captured data on its rdata; -> IDLE.
REQ-018 Requesters are not sampled in DONE; a request still held after its ready pulse is treated as a new request in IDLE.
REQ-019 if_rdata/d_rdata SHALL hold their last captured value between completions; d_rdata for stores = value returned with ack.
REQ-020 Minimum latency: request sampled in IDLE at cycle 0 -> ISSUE cycle 1 -> ack cycle 1 -> ready cycle 2.
REQ-021 Back-to-back throughput: one transaction per 3 cycles minimum (IDLE, ISSUE, DONE).
REQ-022 8-bit timeout counter SHALL clear on entry to ISSUE and count each ISSUE/WAIT cycle without ack.
REQ-023 Count reaching TIMEOUT -> err=1 (sticky until reset), captured data = 0, -> DONE with normal ready pulse.
REQ-024 Ack in the same cycle the count reaches TIMEOUT SHALL win: normal completion, err unchanged.
REQ-025 stall_if = if_req & ~if_ready; stall_m = d_req & ~d_ready (combinational).
REQ-026 Latched request fields SHALL NOT change mid-transaction if requester inputs change or drop.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, last_grant=IF, counter=0, err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0.
REQ-028 Reset mid-transaction SHALL abandon it with no ready pulse; after release, requests are re-arbitrated from IDLE.
REQ-029 Release of reset SHALL take effect on the first rising clk edge after reset=1.

Verification
REQ-030 if_req=1 alone, if_addr=0x100, ack in ISSUE with rdata=0x00500093 -> mem_en cycle 1, if_ready cycle 2, if_rdata=0x00500093.
REQ-031 Both requests from reset, d_we=1 d_addr=0x200 d_wdata=0xDEADBEEF -> data granted first (mem_we=1, mem_addr=0x200), IF granted next; both complete.
REQ-032 Both requests held continuously for 6 transactions -> grants alternate D,I,D,I,D,I.
REQ-033 d_req load, mem_ack delayed 3 cycles after ISSUE -> stall_m=1 throughout, d_ready exactly 1 cycle, mem_en exactly 1 cycle.
REQ-034 mem_ack never asserted, TIMEOUT=15 -> after 15 ISSUE/WAIT cycles, err=1, d_ready pulse with d_rdata=0; err persists until reset.
REQ-035 reset=0 asserted in WAIT -> outputs at reset values immediately (no clk edge); no ready pulse; after release, pending request re-issued.
